pc_unit: RTL and testbench

Parametrised program-counter and fetch sequencer, the next generation of the core PC register. It adds:
- a valid/ready fetch handshake and pipeline stall;
- branch/jump redirect with optional MIPS branch-delay-slot sequencing;
- exception vectoring with EPC/cause capture, and ERET return;
- alignment checking of redirect targets.

It sits between the control/hazard logic and instruction memory.

---
 rtl/pc_unit.sv | 77 +++++++
 tb/tb_pc_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter / fetch sequencer with redirect, delay slot, exception and ERET handling.
// One-cycle latency from any triggering edge to pc; fetch_valid drops on stall or reset, fetch_ready gates advance.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0040_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
  parameter int               INC          = 4,
  parameter bit               DELAY_SLOT   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  output logic [WIDTH-1:0] epc,
  output logic [4:0]       cause,
  output logic             exl
);

  localparam logic [4:0] CAUSE_ADEL = 5'd4;

  logic             fire;
  logic             misaligned;
  logic             pending;
  logic [WIDTH-1:0] pending_target;

  assign fetch_valid = !reset && !stall;
  assign fire        = fetch_valid && fetch_ready;
  assign misaligned  = redirect_valid && (redirect_target[1:0] != 2'b00);

  // Strict priority: trap, eret, redirect, pending delay-slot target, sequential.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_VECTOR;
      epc            <= '0;
      cause          <= '0;
      exl            <= 1'b0;
      pending        <= 1'b0;
      pending_target <= '0;
    end else if (exc_valid || misaligned) begin
      pc      <= EXC_VECTOR;
      pending <= 1'b0;
      // Nested traps revector but keep the outer handler's state.
      if (!exl) begin
        epc   <= exc_valid ? exc_pc : redirect_target;
        cause <= exc_valid ? exc_code : CAUSE_ADEL;
        exl   <= 1'b1;
      end
    end else if (eret && exl) begin
      pc      <= epc;
      exl     <= 1'b0;
      pending <= 1'b0;
    end else if (redirect_valid) begin
      // With a delay slot, the current pc is the slot; jump only once it has been fetched.
      if (!DELAY_SLOT || fire) begin
        pc      <= redirect_target;
        pending <= 1'b0;
      end else begin
        pending        <= 1'b1;
        pending_target <= redirect_target;
      end
    end else if (fire && pending) begin
      pc      <= pending_target;
      pending <= 1'b0;
    end else if (fire) begin
      pc <= pc + WIDTH'(INC);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench: one delay-slot instance and one immediate-redirect instance on shared stimulus.
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret;

  logic        fv1, exl1, fv0, exl0;
  logic [31:0] pc1, epc1, pc0, epc0;
  logic [4:0]  cause1, cause0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_unit #(.DELAY_SLOT(1'b1)) dut_ds (
    .clock(clock), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fv1), .pc(pc1), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .eret(eret), .epc(epc1), .cause(cause1), .exl(exl1)
  );

  pc_unit #(.DELAY_SLOT(1'b0)) dut_nds (
    .clock(clock), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fv0), .pc(pc0), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .eret(eret), .epc(epc0), .cause(cause0), .exl(exl0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; eret = 1'b0;
    #1;
    chk("fv_in_reset", {31'b0, fv1}, 32'h0);
    tick(); tick();
    chk("rst_pc",    pc1, 32'h0040_0000);
    chk("rst_epc",   epc1, 32'h0);
    chk("rst_cause", {27'b0, cause1}, 32'h0);
    chk("rst_exl",   {31'b0, exl1}, 32'h0);
    chk("rst_fv",    {31'b0, fv1}, 32'h0);

    // Sequential fetch
    reset = 1'b0; fetch_ready = 1'b1;
    #1;
    chk("fv_run", {31'b0, fv1}, 32'h1);
    chk("seq0", pc1, 32'h0040_0000);
    tick(); chk("seq1", pc1, 32'h0040_0004);
    tick(); chk("seq2", pc1, 32'h0040_0008);

    // Stall holds pc for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc1, 32'h0040_0008);
      chk("stall_fv", {31'b0, fv1}, 32'h0);
    end
    stall = 1'b0;
    tick(); chk("unstall", pc1, 32'h0040_000C);
    tick(); chk("seq4_ds", pc1, 32'h0040_0010);
    chk("seq4_nds", pc0, 32'h0040_0010);

    // Redirect without fire: delay slot waits, immediate jumps
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
    tick();
    chk("ds_hold",  pc1, 32'h0040_0010);
    chk("nds_jump", pc0, 32'h0040_0100);
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    tick();
    chk("ds_pend_jump", pc1, 32'h0040_0100);
    chk("nds_seq",      pc0, 32'h0040_0104);

    // Exception entry
    exc_valid = 1'b1; exc_pc = 32'h0040_0020; exc_code = 5'd12;
    tick();
    chk("exc_pc",    pc1, 32'h8000_0180);
    chk("exc_epc",   epc1, 32'h0040_0020);
    chk("exc_cause", {27'b0, cause1}, 32'd12);
    chk("exc_exl",   {31'b0, exl1}, 32'h1);
    chk("exc_pc_nds", pc0, 32'h8000_0180);
    exc_valid = 1'b0;
    tick(); chk("handler_seq", pc1, 32'h8000_0184);

    // Nested exception keeps the saved state
    exc_valid = 1'b1; exc_pc = 32'h8000_0184; exc_code = 5'd8;
    tick();
    chk("nest_pc",    pc1, 32'h8000_0180);
    chk("nest_epc",   epc1, 32'h0040_0020);
    chk("nest_cause", {27'b0, cause1}, 32'd12);
    chk("nest_exl",   {31'b0, exl1}, 32'h1);

    // ERET beats fire
    exc_valid = 1'b0; eret = 1'b1;
    tick();
    chk("eret_pc",  pc1, 32'h0040_0020);
    chk("eret_exl", {31'b0, exl1}, 32'h0);
    chk("eret_exl_nds", {31'b0, exl0}, 32'h0);

    // ERET with exl=0 is ignored
    fetch_ready = 1'b0;
    tick();
    chk("eret0_hold", pc1, 32'h0040_0020);
    chk("eret0_exl",  {31'b0, exl1}, 32'h0);
    fetch_ready = 1'b1;
    tick();
    chk("eret0_fallthru", pc1, 32'h0040_0024);

    // Misaligned redirect traps
    eret = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
    tick();
    chk("mis_pc",    pc1, 32'h8000_0180);
    chk("mis_cause", {27'b0, cause1}, 32'd4);
    chk("mis_epc",   epc1, 32'h0040_0102);
    chk("mis_exl",   {31'b0, exl1}, 32'h1);
    chk("mis_pc_nds", pc0, 32'h8000_0180);

    // Exception and eret together: exception wins
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    tick(); chk("handler_seq2", pc1, 32'h8000_0184);
    fetch_ready = 1'b0; exc_valid = 1'b1; eret = 1'b1; exc_pc = 32'h8000_0184; exc_code = 5'd10;
    tick();
    chk("exc_eret_pc",  pc1, 32'h8000_0180);
    chk("exc_eret_exl", {31'b0, exl1}, 32'h1);
    chk("exc_eret_epc", epc1, 32'h0040_0102);

    // Reset discards a pending redirect
    exc_valid = 1'b0; eret = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0200;
    tick();
    chk("pend_hold", pc1, 32'h8000_0180);
    chk("pend_nds",  pc0, 32'h0040_0200);
    redirect_valid = 1'b0; reset = 1'b1;
    tick();
    chk("rst2_pc",    pc1, 32'h0040_0000);
    chk("rst2_exl",   {31'b0, exl1}, 32'h0);
    chk("rst2_epc",   epc1, 32'h0);
    chk("rst2_cause", {27'b0, cause1}, 32'h0);
    chk("rst2_fv",    {31'b0, fv1}, 32'h0);
    reset = 1'b0; fetch_ready = 1'b1;
    tick();
    chk("rst2_nopend", pc1, 32'h0040_0004);

    // Redirect with fire jumps directly, then wraps
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    chk("fire_jump", pc1, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    chk("wrap",     pc1, 32'h0);
    chk("wrap_nds", pc0, 32'h0);

    // Redirect captured during stall, taken after stall drops
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0300;
    tick();
    chk("stall_cap", pc1, 32'h0);
    chk("stall_cap_nds", pc0, 32'h0040_0300);
    redirect_valid = 1'b0;
    tick();
    chk("stall_pend_hold", pc1, 32'h0);
    stall = 1'b0;
    tick();
    chk("stall_pend_jump", pc1, 32'h0040_0300);
    chk("stall_nds_seq",   pc0, 32'h0040_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
